uart_dbg_cmd_parser: RTL and testbench
======================================

# uart_dbg_cmd_parser

Debug-link initiator between the UART byte receiver/transmitter and the instruction/data memory debug ports. It assembles incoming UART bytes into read/write command frames and issues single-cycle memory requests on the shared debug request bus. It collects the memory's 42-bit read response or a write completion, then streams reply bytes back to the UART transmitter.

## Interface
Parameters:
- `TIMEOUT`, default 16: cycles to wait for `resp_ready` after a read request before sending a NAK.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `rx_byte`  in  8  byte from the UART receiver.
- `rx_valid`  in  1  one-cycle strobe; `rx_byte` is valid.
- `tx_byte`  out  8  reply byte to the UART transmitter.
- `tx_valid`  out  1  `tx_byte` is valid; held until accepted.
- `tx_ready`  in  1  transmitter accepts a byte when `tx_valid & tx_ready` at a clock edge.
- `cpu_enable`  in  1  CPU running. Requests are forbidden while it is high.
- `write_mem_req`  out  1  one-cycle request pulse.
- `target_mem_type`  out  1  1 selects instruction memory, 0 selects data memory.
- `target_addr`  out  9  word address.
- `uart_rx_data_in`  out  32  write data.
- `rw_flag`  out  1  1 is write, 0 is read.
- `resp_data`  in  42  read response `{1'b1, addr[8:0], data[31:0]}`, ORed from both memories.
- `resp_ready`  in  1  one-cycle pulse; `resp_data` is valid.
- `busy`  out  1  high in every state except HDR.
- `rx_drop`  out  1  one-cycle pulse when an rx byte is discarded.

## Operation
Frame format:
- Header byte: `{rw, mem_type, 5'b00000, addr[8]}`.
- Address byte: `addr[7:0]`.
- Data bytes, writes only: 4 bytes, MSB first.

States:
- **HDR**: on `rx_valid`:
  - If bits [5:1] are nonzero, load NAK `0xEE` and go to SEND.
  - Otherwise latch `rw`, `mem_type` and `addr[8]`, then go to ADDR.
- **ADDR**: on `rx_valid`, latch `addr[7:0]`. Go to DATA if `rw`=1, else ISSUE.
- **DATA**: shift in 4 bytes MSB first, with the byte counter 0..3. After the 4th byte go to ISSUE.
- **ISSUE** (1 cycle):
  - If `cpu_enable`=1: no request; load NAK and go to SEND.
  - Otherwise assert `write_mem_req` for exactly this cycle, with `target_*`, `rw_flag` and `uart_rx_data_in` driven from the latches.
  - Write: load ACK `0xAA` and go to SEND.
  - Read: clear the timeout counter and go to WAIT.
- **WAIT**: on `resp_ready`, load `{6'b0, resp_data}` (48 bits, sent as 6 bytes MSB first) and go to SEND. When the counter reaches `TIMEOUT-1` without `resp_ready`, load NAK and go to SEND.
- **SEND**: present bytes on `tx_byte`/`tx_valid` and advance on each accept. After the last byte, deassert `tx_valid` and return to HDR.
- Any `rx_valid` outside HDR/ADDR/DATA is dropped with an `rx_drop` pulse. There is no queueing.

Output behaviour:
- `target_*`, `rw_flag` and `uart_rx_data_in` are registered and hold their last values between requests.
- `write_mem_req` is never high for two consecutive cycles.

## Timing
- Reset (reset=0 at an edge): state HDR. All outputs are 0: `write_mem_req`, `tx_valid`, `tx_byte`, `target_addr`, `target_mem_type`, `rw_flag`, `uart_rx_data_in`, `busy`, `rx_drop`. All counters are cleared.
- Reset mid-frame or mid-SEND aborts the frame with no further tx bytes.
- Request latency: `write_mem_req` is high in the cycle after the edge that accepted the final frame byte.
- `resp_ready` is legal from the cycle after the request. `resp_ready` in the request cycle itself is ignored.
- Write ACK: `tx_valid` rises in the cycle after the request.
- `tx_byte` must not change while `tx_valid=1 & tx_ready=0`. Back-to-back accepts advance one byte per cycle.
- `resp_ready` arriving in the same cycle the timeout expires: the response wins.
- A late `resp_ready` in any state other than WAIT is ignored.

## Structure
- Package `uart_dbg_pkg` holds:
  - `ACK_BYTE=8'hAA`, `NAK_BYTE=8'hEE`
  - the header bit positions
  - `RESP_W=42`, `ADDR_W=9`
  - the state enum
- One sub-module, `dbg_resp_shifter`: a 6-byte load/shift register with the valid/ready handshake and a byte-length input (1 or 6). The parser FSM drives it in SEND.

## Test plan
- Write: rx `C0 05 00 10 80 93`, `cpu_enable`=0 -> one request pulse with addr=0x005, mem_type=1, rw=1, data=0x00108093; tx `AA`.
- Read: rx `41 05`; bench returns `resp_ready` 1 cycle after the request with `resp_data={1,9'h105,32'h00000013}` -> tx `03 05 00 00 00 13` MSB first; `busy` falls after the last accept.
- Timeout: rx `01 20` with no `resp_ready` -> tx `EE` starts TIMEOUT cycles after the request; a `resp_ready` injected afterwards produces no tx.
- Guard and reserved bits:
  - `cpu_enable`=1 with rx `80 00 00 00 00 01` -> no `write_mem_req`; tx `EE`.
  - Header `3E` -> tx `EE` immediately.
- Backpressure and drops: during the read reply, hold `tx_ready`=0 for 5 cycles per byte -> `tx_byte` stable and all 6 bytes delivered; rx bytes sent during SEND pulse `rx_drop` and do not start a frame.
- Reset mid-frame: rx `C0 05 00`, then reset=0 for 1 cycle -> no request, all outputs 0; a following `41 05` read completes normally.

Source files
------------

// File: rtl/uart_dbg_pkg.sv
// Shared constants, header layout and FSM encoding for the UART debug
// command parser and its reply shifter.
package uart_dbg_pkg;

    localparam logic [7:0] ACK_BYTE = 8'hAA;
    localparam logic [7:0] NAK_BYTE = 8'hEE;

    localparam int HDR_RW     = 7;
    localparam int HDR_MEM    = 6;
    localparam int HDR_RSV_HI = 5;
    localparam int HDR_RSV_LO = 1;
    localparam int HDR_A8     = 0;

    localparam int RESP_W  = 42;
    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 32;
    localparam int REPLY_W = 48;

    localparam logic [2:0] LEN_ONE  = 3'd1;
    localparam logic [2:0] LEN_RESP = 3'd6;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_ADDR,
        ST_DATA,
        ST_ISSUE,
        ST_WAIT,
        ST_SEND
    } state_t;

    // Single-byte replies sit in the top byte so they leave first.
    function automatic logic [REPLY_W-1:0] single_byte(input logic [7:0] b);
        return {b, {(REPLY_W-8){1'b0}}};
    endfunction

endpackage

// File: rtl/dbg_resp_shifter.sv
// Six-byte reply register: parallel load, then MSB-first byte stream
// over a valid/ready handshake.
module dbg_resp_shifter
    import uart_dbg_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [REPLY_W-1:0] load_data,
    input  logic [2:0]         load_len,
    output logic [7:0]         tx_byte,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               done
);

    logic [REPLY_W-1:0] sr;
    logic [2:0]         left;
    logic               accept;

    assign tx_byte = sr[REPLY_W-1 -: 8];
    assign accept  = tx_valid & tx_ready;
    assign done    = accept & (left == 3'd1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr       <= '0;
            left     <= '0;
            tx_valid <= 1'b0;
        end else if (load) begin
            sr       <= load_data;
            left     <= load_len;
            tx_valid <= (load_len != 3'd0);
        end else if (accept) begin
            sr   <= {sr[REPLY_W-9:0], 8'h00};
            left <= left - 3'd1;
            if (left == 3'd1) begin
                tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_dbg_cmd_parser.sv
// UART debug initiator: builds read/write frames from rx bytes, issues a
// one-cycle memory request and streams the ACK/NAK/read reply back.
module uart_dbg_cmd_parser
    import uart_dbg_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic [7:0]        tx_byte,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic              cpu_enable,
    output logic              write_mem_req,
    output logic              target_mem_type,
    output logic [ADDR_W-1:0] target_addr,
    output logic [DATA_W-1:0] uart_rx_data_in,
    output logic              rw_flag,
    input  logic [RESP_W-1:0] resp_data,
    input  logic              resp_ready,
    output logic              busy,
    output logic              rx_drop
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    // Reply load lags the decision by one edge, so expire one count early.
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 2);

    state_t       state;
    logic         hdr_rw;
    logic         hdr_mem;
    logic         addr_hi;
    logic [7:0]   addr_lo;
    logic [23:0]  data_sr;
    logic [1:0]   byte_cnt;
    logic [TW-1:0] tcnt;

    logic               rsv_bad;
    logic               expired;
    logic               sh_load;
    logic [REPLY_W-1:0] sh_data;
    logic [2:0]         sh_len;
    logic               sh_done;

    assign rsv_bad = |rx_byte[HDR_RSV_HI:HDR_RSV_LO];
    assign expired = (tcnt == T_LAST);
    assign busy    = (state != ST_HDR);

    always_comb begin
        sh_load = 1'b0;
        sh_data = single_byte(NAK_BYTE);
        sh_len  = LEN_ONE;
        unique case (state)
            ST_HDR: begin
                if (rx_valid && rsv_bad) begin
                    sh_load = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (!write_mem_req) begin
                    sh_load = 1'b1;
                end else if (hdr_rw) begin
                    sh_load = 1'b1;
                    sh_data = single_byte(ACK_BYTE);
                end
            end
            ST_WAIT: begin
                if (resp_ready) begin
                    sh_load = 1'b1;
                    sh_data = {{(REPLY_W-RESP_W){1'b0}}, resp_data};
                    sh_len  = LEN_RESP;
                end else if (expired) begin
                    sh_load = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= ST_HDR;
            hdr_rw          <= 1'b0;
            hdr_mem         <= 1'b0;
            addr_hi         <= 1'b0;
            addr_lo         <= '0;
            data_sr         <= '0;
            byte_cnt        <= '0;
            tcnt            <= '0;
            write_mem_req   <= 1'b0;
            target_mem_type <= 1'b0;
            target_addr     <= '0;
            uart_rx_data_in <= '0;
            rw_flag         <= 1'b0;
            rx_drop         <= 1'b0;
        end else begin
            write_mem_req <= 1'b0;
            rx_drop       <= 1'b0;
            unique case (state)
                ST_HDR: begin
                    if (rx_valid) begin
                        if (rsv_bad) begin
                            state <= ST_SEND;
                        end else begin
                            hdr_rw  <= rx_byte[HDR_RW];
                            hdr_mem <= rx_byte[HDR_MEM];
                            addr_hi <= rx_byte[HDR_A8];
                            state   <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rx_valid) begin
                        addr_lo  <= rx_byte;
                        byte_cnt <= '0;
                        if (hdr_rw) begin
                            state <= ST_DATA;
                        end else begin
                            state         <= ST_ISSUE;
                            write_mem_req <= !cpu_enable;
                            if (!cpu_enable) begin
                                target_mem_type <= hdr_mem;
                                target_addr     <= {addr_hi, rx_byte};
                                rw_flag         <= 1'b0;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_valid) begin
                        data_sr  <= {data_sr[15:0], rx_byte};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state         <= ST_ISSUE;
                            write_mem_req <= !cpu_enable;
                            if (!cpu_enable) begin
                                target_mem_type <= hdr_mem;
                                target_addr     <= {addr_hi, addr_lo};
                                rw_flag         <= 1'b1;
                                uart_rx_data_in <= {data_sr, rx_byte};
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    tcnt  <= '0;
                    state <= (write_mem_req && !hdr_rw) ? ST_WAIT : ST_SEND;
                end
                ST_WAIT: begin
                    tcnt <= tcnt + 1'b1;
                    if (resp_ready || expired) begin
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (sh_done) begin
                        state <= ST_HDR;
                    end
                end
                default: state <= ST_HDR;
            endcase
            if (rx_valid && (state == ST_ISSUE || state == ST_WAIT ||
                             state == ST_SEND)) begin
                rx_drop <= 1'b1;
            end
        end
    end

    dbg_resp_shifter u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (sh_load),
        .load_data (sh_data),
        .load_len  (sh_len),
        .tx_byte   (tx_byte),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .done      (sh_done)
    );

endmodule

// File: tb/tb_uart_dbg_cmd_parser.sv
// Randomized frame-level bench for uart_dbg_cmd_parser with a
// transaction model of requests, reply bytes and reply start times.
module tb_uart_dbg_cmd_parser;

    localparam int TIMEOUT = 16;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int          c;
        logic        mem;
        logic [8:0]  addr;
        logic        rw;
        logic [31:0] data;
    } req_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        cpu_enable;
    logic        write_mem_req;
    logic        target_mem_type;
    logic [8:0]  target_addr;
    logic [31:0] uart_rx_data_in;
    logic        rw_flag;
    logic [41:0] resp_data;
    logic        resp_ready;
    logic        busy;
    logic        rx_drop;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   drop_cnt = 0;
    int   bp_mode = 0;
    int   bp_ph = 0;
    logic txv_d = 1'b0;
    bq_t  tx_q;
    req_t req_q[$];
    int   rise_q[$];

    always #5 clk = ~clk;

    uart_dbg_cmd_parser #(.TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_byte         (rx_byte),
        .rx_valid        (rx_valid),
        .tx_byte         (tx_byte),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .cpu_enable      (cpu_enable),
        .write_mem_req   (write_mem_req),
        .target_mem_type (target_mem_type),
        .target_addr     (target_addr),
        .uart_rx_data_in (uart_rx_data_in),
        .rw_flag         (rw_flag),
        .resp_data       (resp_data),
        .resp_ready      (resp_ready),
        .busy            (busy),
        .rx_drop         (rx_drop)
    );

    // Cycle c is the interval in which cyc == c.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        txv_d <= tx_valid;
        if (write_mem_req)
            req_q.push_back('{c: cyc, mem: target_mem_type, addr: target_addr,
                              rw: rw_flag, data: uart_rx_data_in});
        if (tx_valid && !txv_d)
            rise_q.push_back(cyc);
        if (tx_valid && tx_ready)
            tx_q.push_back(tx_byte);
        if (rx_drop)
            drop_cnt <= drop_cnt + 1;
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode == 0) begin
                tx_ready = 1'b1;
            end else if (bp_mode == 1) begin
                tx_ready = ($urandom_range(0, 2) != 0);
            end else begin
                bp_ph = (bp_ph + 1) % 6;
                tx_ready = (bp_ph == 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Frame-level reference: what a frame should produce, from the rules.
    function automatic void model(input bq_t b, input bit cpu_en, input int d,
                                  input logic [41:0] resp, input int f,
                                  output bit ereq, output req_t er,
                                  output bq_t etx, output int erise);
        logic [7:0]  h;
        logic [47:0] w;
        h = b[0];
        etx = {};
        ereq = 1'b0;
        er = '{c: f + 1, mem: h[6], addr: 9'd0, rw: h[7], data: 32'd0};
        erise = 0;
        if (h[5:1] != 5'd0) begin
            etx.push_back(8'hEE);
            erise = f + 1;
            return;
        end
        er.addr = {h[0], b[1]};
        if (er.rw)
            er.data = {b[2], b[3], b[4], b[5]};
        if (cpu_en) begin
            etx.push_back(8'hEE);
            erise = f + 2;
            return;
        end
        ereq = 1'b1;
        if (er.rw) begin
            etx.push_back(8'hAA);
            erise = f + 2;
        end else if (d >= 1 && d <= TIMEOUT - 1) begin
            w = {6'd0, resp};
            for (int i = 5; i >= 0; i--)
                etx.push_back(w[8*i +: 8]);
            erise = f + 2 + d;
        end else begin
            etx.push_back(8'hEE);
            erise = f + 1 + TIMEOUT;
        end
    endfunction

    // d: cycles after the request to pulse resp_ready (<0: never).
    task automatic do_frame(input string name, input bq_t b, input bit cpu_en,
                            input int d, input logic [41:0] resp,
                            input int gap_max, input bit stall_chk,
                            input int drops);
        bq_t  etx;
        req_t er;
        bit   ereq;
        int   erise;
        int   f;
        int   tx0;
        int   rq0;
        int   rs0;
        int   dr0;
        int   injected;
        int   k;
        bit   prev_stall;
        logic [7:0] prev_b;
        req_t got;
        f = 0;
        injected = 0;
        prev_stall = 1'b0;
        prev_b = 8'h00;
        tx0 = tx_q.size();
        rq0 = req_q.size();
        rs0 = rise_q.size();
        dr0 = drop_cnt;
        cpu_enable = cpu_en;
        foreach (b[i]) begin
            if (i > 0 && gap_max > 0)
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge clk);
                    #1;
                end
            rx_byte = b[i];
            rx_valid = 1'b1;
            f = cyc;
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
            rx_byte = 8'($urandom);
        end
        model(b, cpu_en, d, resp, f, ereq, er, etx, erise);
        if (d >= 0) begin
            while (cyc < f + 1 + d) begin
                @(posedge clk);
                #1;
            end
            resp_ready = 1'b1;
            resp_data = resp;
            @(posedge clk);
            #1;
            resp_ready = 1'b0;
            resp_data = '0;
        end
        k = 0;
        while (busy && k < 400) begin
            @(negedge clk);
            if (stall_chk) begin
                if (prev_stall) begin
                    checks++;
                    if (tx_byte !== prev_b) begin
                        errors++;
                        $display("FAIL %s stall_hold got %h want %h", name, tx_byte, prev_b);
                    end
                end
                prev_stall = tx_valid && !tx_ready;
                prev_b = tx_byte;
            end
            if (injected < drops && tx_valid && (k % 2 == 0)) begin
                rx_byte = 8'h41;
                rx_valid = 1'b1;
                injected++;
            end else begin
                rx_valid = 1'b0;
            end
            k++;
        end
        rx_valid = 1'b0;
        checks++;
        if (k >= 400) begin
            errors++;
            $display("FAIL %s busy_timeout got busy=%b want 0", name, busy);
        end else if (tx_q.size() - tx0 !== etx.size()) begin
            errors++;
            $display("FAIL %s busy_fall tx_count got %0d want %0d", name, tx_q.size() - tx0, etx.size());
        end
        @(posedge clk);
        #1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (tx_q.size() - tx0 !== etx.size()) begin
            errors++;
            $display("FAIL %s tx_count got %0d want %0d", name, tx_q.size() - tx0, etx.size());
        end else begin
            foreach (etx[i]) begin
                checks++;
                if (tx_q[tx0 + i] !== etx[i]) begin
                    errors++;
                    $display("FAIL %s tx_byte[%0d] got %h want %h", name, i, tx_q[tx0 + i], etx[i]);
                end
            end
        end
        checks++;
        if (req_q.size() - rq0 !== int'(ereq)) begin
            errors++;
            $display("FAIL %s req_count got %0d want %0d", name, req_q.size() - rq0, ereq);
        end else if (ereq) begin
            got = req_q[rq0];
            checks++;
            if (got.c !== er.c || got.mem !== er.mem || got.addr !== er.addr ||
                got.rw !== er.rw || (er.rw && got.data !== er.data)) begin
                errors++;
                $display("FAIL %s req got c=%0d m=%b a=%h rw=%b d=%h want c=%0d m=%b a=%h rw=%b d=%h",
                         name, got.c, got.mem, got.addr, got.rw, got.data,
                         er.c, er.mem, er.addr, er.rw, er.data);
            end
        end
        checks++;
        if (rise_q.size() - rs0 !== 1) begin
            errors++;
            $display("FAIL %s tx_rise_count got %0d want 1", name, rise_q.size() - rs0);
        end else if (rise_q[rs0] !== erise) begin
            errors++;
            $display("FAIL %s tx_rise_cycle got %0d want %0d", name, rise_q[rs0], erise);
        end
        checks++;
        if (drop_cnt - dr0 !== drops) begin
            errors++;
            $display("FAIL %s rx_drop_count got %0d want %0d", name, drop_cnt - dr0, drops);
        end
    endtask

    task automatic check_zero(input string name);
        logic [54:0] o;
        o = {write_mem_req, tx_valid, tx_byte, target_addr, target_mem_type,
             rw_flag, uart_rx_data_in, busy, rx_drop};
        checks++;
        if (o !== '0) begin
            errors++;
            $display("FAIL %s outputs got %h want 0", name, o);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx_valid = 1'b0;
        rx_byte = 8'h00;
        resp_ready = 1'b0;
        resp_data = '0;
        cpu_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_write();
        do_frame("write", '{8'hC0, 8'h05, 8'h00, 8'h10, 8'h80, 8'h93}, 1'b0, -1, '0, 0, 1'b0, 0);
    endtask

    task automatic test_guard();
        do_frame("guard", '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01}, 1'b1, -1, '0, 0, 1'b0, 0);
        checks++;
        if ({target_mem_type, target_addr, rw_flag, uart_rx_data_in} !==
            {1'b1, 9'h005, 1'b1, 32'h00108093}) begin
            errors++;
            $display("FAIL guard target_hold got %b %h %b %h want 1 005 1 00108093",
                     target_mem_type, target_addr, rw_flag, uart_rx_data_in);
        end
        cpu_enable = 1'b0;
    endtask

    task automatic test_reserved();
        do_frame("reserved", '{8'h3E}, 1'b0, -1, '0, 0, 1'b0, 0);
    endtask

    task automatic test_read();
        do_frame("read", '{8'h41, 8'h05}, 1'b0, 1, {1'b1, 9'h105, 32'h00000013}, 0, 1'b0, 0);
    endtask

    task automatic test_timeout();
        do_frame("timeout", '{8'h01, 8'h20}, 1'b0, TIMEOUT + 3, {1'b1, 9'h020, 32'h1234}, 0, 1'b0, 0);
        do_frame("resp_in_req_cycle", '{8'h01, 8'h21}, 1'b0, 0, {1'b1, 9'h021, 32'h55}, 0, 1'b0, 0);
        do_frame("resp_tie", '{8'h00, 8'h22}, 1'b0, TIMEOUT - 1, {1'b1, 9'h022, 32'hCAFE}, 0, 1'b0, 0);
        do_frame("resp_after_expiry", '{8'h40, 8'h23}, 1'b0, TIMEOUT, {1'b1, 9'h123, 32'h77}, 0, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        bp_mode = 2;
        do_frame("backpressure", '{8'h41, 8'h05}, 1'b0, 1, {1'b1, 9'h105, 32'hDEADBEEF}, 0, 1'b1, 3);
        bp_mode = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL backpressure idle_after_drop got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int rq0;
        int rs0;
        bq_t pre;
        pre = '{8'hC0, 8'h05, 8'h00};
        rq0 = req_q.size();
        rs0 = rise_q.size();
        cpu_enable = 1'b0;
        foreach (pre[i]) begin
            rx_byte = pre[i];
            rx_valid = 1'b1;
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_zero("reset_mid");
        reset = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (req_q.size() !== rq0 || rise_q.size() !== rs0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid quiet got req=%0d rise=%0d busy=%b want 0 0 0",
                     req_q.size() - rq0, rise_q.size() - rs0, busy);
        end
        do_frame("after_reset", '{8'h41, 8'h05}, 1'b0, 2, {1'b1, 9'h105, 32'h00000013}, 0, 1'b0, 0);
    endtask

    task automatic test_random();
        bq_t b;
        logic [7:0]  h;
        logic [8:0]  a;
        logic [31:0] dat;
        logic [41:0] r;
        bit rw;
        bit mem;
        bit bad;
        bit ce;
        int d;
        bp_mode = 1;
        for (int n = 0; n < 40; n++) begin
            rw = 1'($urandom);
            mem = 1'($urandom);
            bad = ($urandom_range(0, 9) == 0);
            ce = ($urandom_range(0, 4) == 0);
            a = 9'($urandom);
            dat = $urandom;
            h = {rw, mem, bad ? 5'($urandom_range(1, 31)) : 5'd0, a[8]};
            b = {};
            b.push_back(h);
            if (!bad) begin
                b.push_back(a[7:0]);
                if (rw)
                    for (int i = 3; i >= 0; i--)
                        b.push_back(dat[8*i +: 8]);
            end
            r = {1'b1, a, 32'($urandom)};
            d = int'($urandom_range(0, TIMEOUT + 4));
            do_frame("random", b, ce, d, r, 2, 1'b0, 0);
        end
        bp_mode = 0;
        cpu_enable = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_frame("b2b_w0", '{8'h80, 8'h01, 8'hA5, 8'h5A, 8'hFF, 8'h00}, 1'b0, -1, '0, 0, 1'b0, 0);
        do_frame("b2b_w1", '{8'hC1, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04}, 1'b0, -1, '0, 0, 1'b0, 0);
        do_frame("b2b_r", '{8'h41, 8'hFF}, 1'b0, 3, {1'b1, 9'h1FF, 32'h01020304}, 0, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_write();
        test_guard();
        test_reserved();
        test_read();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
